// File: rtl/mips_defs.sv
// Shared definitions for the MIPS fetch path: op encodings for the
// PC sequencer and the address/jump-field widths.
package mips_defs;

  localparam int ADDR_W = 32;
  localparam int JUMP_W = 26;

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_J    = 3'd1,
    OP_JR   = 3'd2,
    OP_BGT  = 3'd3,
    OP_JAL  = 3'd4,
    OP_RET  = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: pushes past capacity overwrite the
// oldest entry, and pops of an empty stack are ignored but reported.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow_evt,
  output logic             underflow_evt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;     // next slot to write; top entry sits just below
  logic [CNT_W-1:0] count;

  assign empty         = (count == '0);
  assign full          = (count == CNT_W'(DEPTH));
  assign top           = mem[ptr - PTR_W'(1)];
  assign overflow_evt  = push && full;
  assign underflow_evt = pop && !push && empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

  // NOTE: the entry array has no reset; count guarantees no stale entry is ever consumed.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and next-PC generator: sequential advance, J/JR/BGT,
// JAL/RET via a return-address stack, with stall and sticky error flags.
module pc_sequencer
  import mips_defs::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                RAS_DEPTH  = 4,
  parameter bit                BGT_SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [2:0]        op,
  input  logic [JUMP_W-1:0] jump_target,
  input  logic [15:0]       branch_offset,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic [ADDR_W-1:0] rt_val,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] link_addr,
  output logic              redirect,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ras_underflow,
  output logic              misaligned
);

  op_e               opCode;
  logic [ADDR_W-1:0] pcReg, linkReg, nextPc, rasTop;
  logic [ADDR_W-1:0] jTarget, rsTarget, branchTarget;
  logic              redirectReg, redirectNext;
  logic              overflowReg, underflowReg, misalignedReg, misalignedEvt;
  logic              rasPush, rasPop, rasOverflowEvt, rasUnderflowEvt;
  logic              bgtTaken;

  assign opCode       = op_e'(op);
  assign pc_plus4     = pcReg + 32'd4;
  assign jTarget      = {pc_plus4[31:28], jump_target, 2'b00};
  assign rsTarget     = {rs_val[31:2], 2'b00};
  assign branchTarget = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign bgtTaken     = BGT_SIGNED ? ($signed(rs_val) > $signed(rt_val)) : (rs_val > rt_val);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    nextPc        = pc_plus4;
    redirectNext  = 1'b0;
    rasPush       = 1'b0;
    rasPop        = 1'b0;
    misalignedEvt = 1'b0;
    if (!stall) begin
      case (opCode)
        OP_J: begin
          nextPc       = jTarget;
          redirectNext = 1'b1;
        end
        OP_JR: begin
          nextPc        = rsTarget;
          redirectNext  = 1'b1;
          misalignedEvt = |rs_val[1:0];
        end
        OP_BGT: begin
          if (bgtTaken) nextPc = branchTarget;
          redirectNext = bgtTaken;
        end
        OP_JAL: begin
          nextPc       = jTarget;
          redirectNext = 1'b1;
          rasPush      = 1'b1;
        end
        OP_RET: begin
          // Only the rs_val fallback can be misaligned; stacked entries are pc+4 values.
          rasPop        = 1'b1;
          nextPc        = ras_empty ? rsTarget : rasTop;
          misalignedEvt = ras_empty && (|rs_val[1:0]);
          redirectNext  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clk           (clk),
    .rst_n         (rst_n),
    .push          (rasPush),
    .pop           (rasPop),
    .push_data     (pc_plus4),
    .top           (rasTop),
    .empty         (ras_empty),
    .full          (ras_full),
    .overflow_evt  (rasOverflowEvt),
    .underflow_evt (rasUnderflowEvt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcReg         <= RESET_PC;
      linkReg       <= '0;
      redirectReg   <= 1'b0;
      overflowReg   <= 1'b0;
      underflowReg  <= 1'b0;
      misalignedReg <= 1'b0;
    end else begin
      redirectReg <= redirectNext;
      if (!stall)          pcReg         <= nextPc;
      if (rasPush)         linkReg       <= pc_plus4;
      if (rasOverflowEvt)  overflowReg   <= 1'b1;
      if (rasUnderflowEvt) underflowReg  <= 1'b1;
      if (misalignedEvt)   misalignedReg <= 1'b1;
    end
  end

  assign pc            = pcReg;
  assign link_addr     = linkReg;
  assign redirect      = redirectReg;
  assign ras_overflow  = overflowReg;
  assign ras_underflow = underflowReg;
  assign misaligned    = misalignedReg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// RAS/misalign/stall sequences, and random ops against a queue-based model.
module tb_pc_sequencer;

  localparam logic [31:0] RPC   = 32'h0040_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [25:0] jt = '0;
  logic [15:0] off = '0;
  logic [31:0] rs = '0, rt = '0;

  logic [31:0] pcS, p4S, linkS, pcU, p4U, linkU;
  logic        redS, emS, fuS, ovS, unS, miS;
  logic        redU, emU, fuU, ovU, unU, miU;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(RPC), .RAS_DEPTH(DEPTH), .BGT_SIGNED(1'b1)) dutS (
    .clk(clk), .rst_n(rst_n), .stall(stall), .op(op), .jump_target(jt),
    .branch_offset(off), .rs_val(rs), .rt_val(rt), .pc(pcS), .pc_plus4(p4S),
    .link_addr(linkS), .redirect(redS), .ras_empty(emS), .ras_full(fuS),
    .ras_overflow(ovS), .ras_underflow(unS), .misaligned(miS));

  pc_sequencer #(.RESET_PC(RPC), .RAS_DEPTH(DEPTH), .BGT_SIGNED(1'b0)) dutU (
    .clk(clk), .rst_n(rst_n), .stall(stall), .op(op), .jump_target(jt),
    .branch_offset(off), .rs_val(rs), .rt_val(rt), .pc(pcU), .pc_plus4(p4U),
    .link_addr(linkU), .redirect(redU), .ras_empty(emU), .ras_full(fuU),
    .ras_overflow(ovU), .ras_underflow(unU), .misaligned(miU));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model (signed-BGT instance): the RAS is a plain queue, newest at the back.
  logic [31:0] mPc, mLink;
  logic        mRed, mOvf, mUnf, mMis;
  logic [31:0] mRas[$];

  task automatic modelReset();
    mPc = RPC; mLink = 0; mRed = 0; mOvf = 0; mUnf = 0; mMis = 0;
    mRas.delete();
  endtask

  task automatic modelStep();
    logic [31:0] p4, np;
    int offWords;
    if (stall) begin
      mRed = 0;
      return;
    end
    p4 = mPc + 32'd4;
    np = p4;
    mRed = 1;
    case (op)
      3'd1: np = {p4[31:28], jt, 2'b00};
      3'd2: begin
        np = rs & ~32'd3;
        if (rs[1:0] != 0) mMis = 1;
      end
      3'd3: begin
        offWords = $signed(off);
        mRed = ($signed(rs) > $signed(rt));
        if (mRed) np = p4 + 32'(offWords * 4);
      end
      3'd4: begin
        np = {p4[31:28], jt, 2'b00};
        mRas.push_back(p4);
        if (mRas.size() > DEPTH) begin
          void'(mRas.pop_front());
          mOvf = 1;
        end
        mLink = p4;
      end
      3'd5: begin
        if (mRas.size() > 0) np = mRas.pop_back();
        else begin
          np = rs & ~32'd3;
          mUnf = 1;
          if (rs[1:0] != 0) mMis = 1;
        end
      end
      default: mRed = 0;
    endcase
    mPc = np;
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".pc"}, pcS, mPc);
    check({tag, ".pc_plus4"}, p4S, mPc + 32'd4);
    check({tag, ".link"}, linkS, mLink);
    check({tag, ".redirect"}, 32'(redS), 32'(mRed));
    check({tag, ".empty"}, 32'(emS), 32'(mRas.size() == 0));
    check({tag, ".full"}, 32'(fuS), 32'(mRas.size() == DEPTH));
    check({tag, ".ovf"}, 32'(ovS), 32'(mOvf));
    check({tag, ".unf"}, 32'(unS), 32'(mUnf));
    check({tag, ".mis"}, 32'(miS), 32'(mMis));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    modelStep();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #2;
    check("rst.pcS", pcS, RPC);
    check("rst.pcU", pcU, RPC);
    check("rst.redirect", 32'(redS), 32'd0);
    rst_n = 1'b1;
    modelReset();
    checkAll("rst");
  endtask

  task automatic setIn(input logic [2:0] o, input logic [25:0] j, input logic [15:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    op = o; jt = j; off = f; rs = a; rt = b;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [25:0] jt;
    logic [15:0] off;
    logic [31:0] rs, rt;
    logic [31:0] expPcS, expPcU;
    logic        expRedS, expRedU;
  } vec_t;

  vec_t vecs[7];
  logic [31:0] rets[5];

  initial begin
    vecs[0] = '{3'd0, 26'h0, 16'h0, 32'h0, 32'h0, 32'h0040_0004, 32'h0040_0004, 1'b0, 1'b0};
    vecs[1] = '{3'd0, 26'h0, 16'h0, 32'h0, 32'h0, 32'h0040_0008, 32'h0040_0008, 1'b0, 1'b0};
    vecs[2] = '{3'd0, 26'h0, 16'h0, 32'h0, 32'h0, 32'h0040_000C, 32'h0040_000C, 1'b0, 1'b0};
    vecs[3] = '{3'd2, 26'h0, 16'h0, 32'h1000_0010, 32'h0, 32'h1000_0010, 32'h1000_0010, 1'b1, 1'b1};
    vecs[4] = '{3'd1, 26'h40, 16'h0, 32'h0, 32'h0, 32'h1000_0100, 32'h1000_0100, 1'b1, 1'b1};
    vecs[5] = '{3'd0, 26'h0, 16'h0, 32'h0, 32'h0, 32'h1000_0104, 32'h1000_0104, 1'b0, 1'b0};
    vecs[6] = '{3'd3, 26'h0, 16'hFFFE, 32'hFFFF_FFFF, 32'h1, 32'h1000_0108, 32'h1000_0100, 1'b0, 1'b1};

    #1;
    doReset();

    for (int i = 0; i < 7; i++) begin
      setIn(vecs[i].op, vecs[i].jt, vecs[i].off, vecs[i].rs, vecs[i].rt);
      tick();
      check($sformatf("vec%0d.pcS", i), pcS, vecs[i].expPcS);
      check($sformatf("vec%0d.pcU", i), pcU, vecs[i].expPcU);
      check($sformatf("vec%0d.redS", i), 32'(redS), 32'(vecs[i].expRedS));
      check($sformatf("vec%0d.redU", i), 32'(redU), 32'(vecs[i].expRedU));
    end

    // Nested calls: 4 JALs then 4 RETs in LIFO order.
    doReset();
    for (int i = 0; i < 4; i++) begin
      rets[i] = pcS + 32'd4;
      setIn(3'd4, 26'h1000 + 26'(i * 16), 16'h0, 32'h0, 32'h0);
      tick();
      check($sformatf("jal%0d.link", i), linkS, rets[i]);
      checkAll($sformatf("jal%0d", i));
    end
    for (int i = 3; i >= 0; i--) begin
      setIn(3'd5, 26'h0, 16'h0, 32'h0000_7770, 32'h0);
      tick();
      check($sformatf("ret%0d.lifo", i), pcS, rets[i]);
      checkAll($sformatf("ret%0d", i));
    end

    // Five JALs overflow; four RETs drain; fifth RET falls back to rs_val.
    for (int i = 0; i < 5; i++) begin
      rets[i] = pcS + 32'd4;
      setIn(3'd4, 26'h2000 + 26'(i * 16), 16'h0, 32'h0, 32'h0);
      tick();
      checkAll($sformatf("ovf_jal%0d", i));
    end
    check("ovf.flag", 32'(ovS), 32'd1);
    for (int i = 4; i >= 1; i--) begin
      setIn(3'd5, 26'h0, 16'h0, 32'h0, 32'h0);
      tick();
      check($sformatf("ovf_ret%0d.lifo", i), pcS, rets[i]);
      checkAll($sformatf("ovf_ret%0d", i));
    end
    setIn(3'd5, 26'h0, 16'h0, 32'h0000_3000, 32'h0);
    tick();
    check("unf.pc", pcS, 32'h0000_3000);
    check("unf.flag", 32'(unS), 32'd1);
    checkAll("unf");

    // Misaligned JR stays flagged.
    setIn(3'd2, 26'h0, 16'h0, 32'h0000_2003, 32'h0);
    tick();
    check("jr_mis.pc", pcS, 32'h0000_2000);
    check("jr_mis.flag", 32'(miS), 32'd1);
    setIn(3'd0, 26'h0, 16'h0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkAll($sformatf("mis_hold%0d", i));
    end

    // Stalled JAL holds everything, then executes exactly once.
    setIn(3'd4, 26'h0000_005, 16'h0, 32'h0, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll($sformatf("stall%0d", i));
    end
    stall = 1'b0;
    tick();
    checkAll("stall_release");
    setIn(3'd0, 26'h0, 16'h0, 32'h0, 32'h0);
    tick();
    checkAll("after_release");
    stall = 1'b1;
    setIn(3'd4, 26'h0000_009, 16'h0, 32'h0, 32'h0);
    tick();
    doReset();
    stall = 1'b0;

    // Random ops against the model.
    for (int n = 0; n < 600; n++) begin
      stall = ($urandom_range(0, 4) == 0);
      op = 3'($urandom_range(0, 7));
      jt = 26'($urandom);
      off = 16'($urandom);
      rs = $urandom;
      rt = $urandom;
      if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) rt = rs + 32'($signed(4'($urandom)));
      tick();
      checkAll($sformatf("rnd%0d", n));
      if (n == 300) doReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
